// File: rtl/err_stat_pkg.sv
// err_stat_pkg: shared types and constants for the error-statistics collector.
// Holds the FSM state enum, operand/product widths and pipeline stage records.
// Optional build macro ERR_STAT_SIGNED_SUM_EN adds a signed difference field to stage 2.
package err_stat_pkg;

    localparam int OPND_W = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Stage 1: exact product alongside the approximate product under test.
    typedef struct packed {
        logic              vld;
        logic [PROD_W-1:0] exact;
        logic [PROD_W-1:0] apprx;
    } stg1_t;

    // Stage 2: per-sample error terms ready for accumulation.
    typedef struct packed {
        logic              vld;
        logic              mis;
        logic [PROD_W-1:0] ed_abs;
`ifdef ERR_STAT_SIGNED_SUM_EN
        logic [PROD_W:0]   diff;
`endif
    } stg2_t;

endpackage

// File: rtl/err_stat_dp.sv
// err_stat_dp: two-stage datapath computing exact product, |exact-apprx| and mismatch.
// Ports: clk_i, rst_i (sync, active-high), vld_i + operands in; stage-2 valid and
// error terms out; pipe_busy_o is high while any stage holds a sample.
// With ERR_STAT_SIGNED_SUM_EN defined, diff_o carries exact-apprx (17-bit two's complement).
module err_stat_dp
    import err_stat_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vld_i,
    input  logic [OPND_W-1:0] a_i,
    input  logic [OPND_W-1:0] b_i,
    input  logic [PROD_W-1:0] apprx_i,
    output logic              vld_o,
    output logic              mis_o,
    output logic [PROD_W-1:0] ed_abs_o,
`ifdef ERR_STAT_SIGNED_SUM_EN
    output logic [PROD_W:0]   diff_o,
`endif
    output logic              pipe_busy_o
);

    stg1_t s1_d, s1_q;
    stg2_t s2_d, s2_q;

    always_comb begin
        s1_d       = s1_q;
        s1_d.vld   = vld_i;
        s1_d.exact = PROD_W'(a_i) * PROD_W'(b_i);
        s1_d.apprx = apprx_i;
    end

    always_comb begin
        s2_d     = s2_q;
        s2_d.vld = s1_q.vld;
        s2_d.mis = (s1_q.exact != s1_q.apprx);
        if (s1_q.exact >= s1_q.apprx) begin
            s2_d.ed_abs = s1_q.exact - s1_q.apprx;
        end else begin
            s2_d.ed_abs = s1_q.apprx - s1_q.exact;
        end
`ifdef ERR_STAT_SIGNED_SUM_EN
        s2_d.diff = {1'b0, s1_q.exact} - {1'b0, s1_q.apprx};
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign vld_o       = s2_q.vld;
    assign mis_o       = s2_q.mis;
    assign ed_abs_o    = s2_q.ed_abs;
`ifdef ERR_STAT_SIGNED_SUM_EN
    assign diff_o      = s2_q.diff;
`endif
    assign pipe_busy_o = s1_q.vld | s2_q.vld;

endmodule

// File: rtl/err_stat_collector8.sv
// err_stat_collector8: collects error statistics of an approximate 8x8 multiplier.
// Ports: clk, rst (sync, active-high), start/num_samples run control, s_valid/s_ready
// sample handshake with s_a, s_b, s_apprx; busy/done status; sample_count, err_count,
// sum_ed_abs, max_ed statistics. Macro ERR_STAT_SIGNED_SUM_EN adds signed output sum_ed.
module err_stat_collector8
    import err_stat_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SUM_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [OPND_W-1:0] s_a,
    input  logic [OPND_W-1:0] s_b,
    input  logic [PROD_W-1:0] s_apprx,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [SUM_W-1:0]  sum_ed_abs,
`ifdef ERR_STAT_SIGNED_SUM_EN
    output logic signed [SUM_W:0] sum_ed,
`endif
    output logic [PROD_W-1:0] max_ed
);

    // The sum of up to 2^CNT_W-1 terms of 16 bits must never wrap.
    if (SUM_W < CNT_W + 16) begin : g_bad_sum_w
        $error("err_stat_collector8: SUM_W must be >= CNT_W+16");
    end

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [CNT_W-1:0]   err_d, err_q;
    logic [SUM_W-1:0]   sum_d, sum_q;
    logic [PROD_W-1:0]  max_d, max_q;
`ifdef ERR_STAT_SIGNED_SUM_EN
    logic signed [SUM_W:0] ssum_d, ssum_q;
    logic [PROD_W:0]    dp_diff;
`endif

    logic               dp_vld;
    logic               dp_mis;
    logic [PROD_W-1:0]  dp_ed_abs;
    logic               dp_busy;

    logic               fire;
    logic               start_ok;
    logic               last_smp;

    assign s_ready  = (state_q == ST_RUN);
    assign fire     = s_valid & s_ready;
    assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign last_smp = (cnt_q == num_q - CNT_W'(1));

    err_stat_dp u_dp (
        .clk_i       (clk),
        .rst_i       (rst),
        .vld_i       (fire),
        .a_i         (s_a),
        .b_i         (s_b),
        .apprx_i     (s_apprx),
        .vld_o       (dp_vld),
        .mis_o       (dp_mis),
        .ed_abs_o    (dp_ed_abs),
`ifdef ERR_STAT_SIGNED_SUM_EN
        .diff_o      (dp_diff),
`endif
        .pipe_busy_o (dp_busy)
    );

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            num_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        num_q <= num_samples;
                        cnt_q <= '0;
                        if (num_samples == '0) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_smp) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Wait until the last sample has left stage 3.
                    if (!dp_busy) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Stage 3 accumulators; a start is only taken with the pipeline empty,
    // so clear and update never collide.
    always_comb begin
        err_d = err_q;
        sum_d = sum_q;
        max_d = max_q;
`ifdef ERR_STAT_SIGNED_SUM_EN
        ssum_d = ssum_q;
`endif
        if (start_ok) begin
            err_d = '0;
            sum_d = '0;
            max_d = '0;
`ifdef ERR_STAT_SIGNED_SUM_EN
            ssum_d = '0;
`endif
        end else if (dp_vld) begin
            if (dp_mis) begin
                err_d = err_q + CNT_W'(1);
            end
            sum_d = sum_q + SUM_W'(dp_ed_abs);
            if (dp_ed_abs > max_q) begin
                max_d = dp_ed_abs;
            end
`ifdef ERR_STAT_SIGNED_SUM_EN
            ssum_d = ssum_q + (SUM_W+1)'($signed(dp_diff));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
            sum_q <= '0;
            max_q <= '0;
`ifdef ERR_STAT_SIGNED_SUM_EN
            ssum_q <= '0;
`endif
        end else begin
            err_q <= err_d;
            sum_q <= sum_d;
            max_q <= max_d;
`ifdef ERR_STAT_SIGNED_SUM_EN
            ssum_q <= ssum_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_count = cnt_q;
    assign err_count    = err_q;
    assign sum_ed_abs   = sum_q;
    assign max_ed       = max_q;
`ifdef ERR_STAT_SIGNED_SUM_EN
    assign sum_ed       = ssum_q;
`endif

endmodule

// File: tb/tb_err_stat_collector8.sv
// tb_err_stat_collector8: directed self-checking bench for err_stat_collector8.
// Build with or without ERR_STAT_SIGNED_SUM_EN; sum_ed is checked only when defined.
module tb_err_stat_collector8;

    localparam int CNT_W = 16;
    localparam int SUM_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_a;
    logic [7:0]       s_b;
    logic [15:0]      s_apprx;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic [SUM_W-1:0] sum_ed_abs;
    logic [15:0]      max_ed;
`ifdef ERR_STAT_SIGNED_SUM_EN
    logic signed [SUM_W:0] sum_ed;
`endif

    int pass_cnt = 0;
    int fail_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    err_stat_collector8 #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_samples  (num_samples),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a          (s_a),
        .s_b          (s_b),
        .s_apprx      (s_apprx),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .sum_ed_abs   (sum_ed_abs),
`ifdef ERR_STAT_SIGNED_SUM_EN
        .sum_ed       (sum_ed),
`endif
        .max_ed       (max_ed)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] n);
        start       = 1'b1;
        num_samples = n;
        tick();
        start       = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] p);
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_apprx = p;
        tick();
        s_valid = 1'b0;
    endtask

    // Called right after the edge accepting the final sample.
    task automatic wait_done(input string tag);
        tick();
        tick();
        check({tag, "_done_early"}, 64'(done), 64'd0);
        check({tag, "_busy_drain"}, 64'(busy), 64'd1);
        tick();
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    task automatic check_stats(input string tag, input int cnt, input int err,
                               input int sum, input int mx);
        check({tag, "_cnt"}, 64'(sample_count), 64'(cnt));
        check({tag, "_err"}, 64'(err_count), 64'(err));
        check({tag, "_sum"}, 64'(sum_ed_abs), 64'(sum));
        check({tag, "_max"}, 64'(max_ed), 64'(mx));
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        s_valid     = 1'b0;
        s_a         = '0;
        s_b         = '0;
        s_apprx     = '0;
        tick();
        tick();
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check_stats("rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Exact sample
        start_run(1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ready", 64'(s_ready), 64'd1);
        send(8'd3, 8'd5, 16'd15);
        check("t1_ready_drain", 64'(s_ready), 64'd0);
        check("t1_cnt_early", 64'(sample_count), 64'd1);
        wait_done("t1");
        check_stats("t1", 1, 0, 0, 0);

        // Worst case, restarted from DONE
        start_run(1);
        check("t2_done_clr", 64'(done), 64'd0);
        check("t2_cnt_clr", 64'(sample_count), 64'd0);
        send(8'd255, 8'd255, 16'd0);
        wait_done("t2");
        check_stats("t2", 1, 1, 65025, 65025);

        // Mixed run, back to back, with an ignored start mid-run
        start_run(3);
        check("t3_stats_clr", 64'(max_ed), 64'd0);
        s_valid = 1'b1;
        s_a = 8'd10; s_b = 8'd10; s_apprx = 16'd96;
        tick();
        s_a = 8'd4;  s_b = 8'd4;  s_apprx = 16'd20;
        start = 1'b1; num_samples = 1;
        tick();
        start = 1'b0;
        check("t3_ready_mid", 64'(s_ready), 64'd1);
        s_a = 8'd0;  s_b = 8'd7;  s_apprx = 16'd0;
        tick();
        s_valid = 1'b0;
        check("t3_ready_drain", 64'(s_ready), 64'd0);
        wait_done("t3");
        check_stats("t3", 3, 2, 8, 4);
`ifdef ERR_STAT_SIGNED_SUM_EN
        check("t3_sum_ed", 64'(sum_ed), 64'd0);
`endif

        // Backpressure: gaps, then s_valid held high past the last transfer
        start_run(2);
        s_valid = 1'b0;
        tick();
        check("t4_cnt0", 64'(sample_count), 64'd0);
        s_valid = 1'b1; s_a = 8'd2; s_b = 8'd3; s_apprx = 16'd6;
        tick();
        check("t4_cnt1", 64'(sample_count), 64'd1);
        s_valid = 1'b0;
        tick();
        check("t4_cnt1_gap", 64'(sample_count), 64'd1);
        s_valid = 1'b1; s_a = 8'd5; s_b = 8'd5; s_apprx = 16'd20;
        tick();
        s_a = 8'd9; s_b = 8'd9; s_apprx = 16'd0;
        check("t4_ready_drain", 64'(s_ready), 64'd0);
        tick();
        check("t4_ready_drain2", 64'(s_ready), 64'd0);
        tick();
        check("t4_done_early", 64'(done), 64'd0);
        tick();
        check("t4_done", 64'(done), 64'd1);
        check("t4_ready_done", 64'(s_ready), 64'd0);
        tick();
        s_valid = 1'b0;
        check_stats("t4", 2, 1, 5, 5);

        // Zero-length run clears the previous statistics
        start_run(0);
        check("t5_done", 64'(done), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check_stats("t5", 0, 0, 0, 0);

        // Reset after 2 of 5 samples, with a start in the reset cycle
        start_run(5);
        s_valid = 1'b1; s_a = 8'd255; s_b = 8'd255; s_apprx = 16'd0;
        tick();
        tick();
        s_valid = 1'b0;
        check("t6_cnt_pre", 64'(sample_count), 64'd2);
        rst = 1'b1; start = 1'b1; num_samples = 1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_ready", 64'(s_ready), 64'd0);
        check_stats("t6", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        check("t6_busy_late", 64'(busy), 64'd0);
        check_stats("t6_late", 0, 0, 0, 0);

        // Start from IDLE after the abort
        start_run(1);
        check("t7_busy", 64'(busy), 64'd1);
        send(8'd7, 8'd6, 16'd40);
        wait_done("t7");
        check_stats("t7", 1, 1, 2, 2);
`ifdef ERR_STAT_SIGNED_SUM_EN
        check("t7_sum_ed", 64'(sum_ed), 64'd2);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/err_stat_collector8.md
ERR_STAT_COLLECTOR8 -- requirements
Module: err_stat_collector8

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of num_samples, sample_count and err_count.
REQ-002 SHALL have parameter SUM_W, default 32: width of sum_ed_abs; the elaboration SHALL fail if SUM_W < CNT_W+16.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a measurement run.
REQ-006 num_samples  input  CNT_W  samples per run; sampled on the accepted start.
REQ-007 s_valid  input  1  sample valid.
REQ-008 s_ready  output  1  collector accepts the sample.
REQ-009 s_a, s_b  input  8 each  multiplier operands.
REQ-010 s_apprx  input  16  approximate product under test.
REQ-011 busy  output  1  high in RUN or DRAIN.
REQ-012 done  output  1  level; high in DONE.
REQ-013 sample_count  output  CNT_W  samples accepted in the current run.
REQ-014 err_count  output  CNT_W  samples where exact != apprx.
REQ-015 sum_ed_abs  output  SUM_W  sum of |exact - apprx|.
REQ-016 max_ed  output  16  maximum |exact - apprx|.

Function
REQ-017 Transfer SHALL occur when s_valid and s_ready are both high in the same cycle.
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-019 The FSM SHALL use these transitions:
- IDLE/DONE + start with num_samples>0 -> RUN, with all statistics cleared in the same edge.
- IDLE/DONE + start with num_samples=0 -> DONE next cycle, with statistics zero.
- RUN -> DRAIN on the edge on which the final (num_samples-th) sample is accepted.
- DRAIN -> DONE once the pipeline is empty.
REQ-020 start in RUN/DRAIN SHALL be ignored.
REQ-021 s_ready SHALL be high only in RUN; it SHALL be combinational from state only, never from s_valid.
REQ-022 Datapath pipeline:
- Stage 1 SHALL register exact = s_a*s_b (16 bit, unsigned) and s_apprx.
- Stage 2 SHALL register ed_abs = |exact - apprx| (16 bit) and mismatch = (exact != apprx).
- Stage 3 SHALL update the accumulators.
REQ-023 Statistics SHALL be updated 3 cycles after acceptance.
REQ-024 done SHALL rise the cycle after the last accumulator update, i.e. 4 cycles after the last accepted sample.
REQ-025 sample_count SHALL increment on acceptance.
REQ-026 err_count SHALL increment on each mismatch.
REQ-027 sum_ed_abs SHALL add ed_abs each sample, with no saturation (width guaranteed by REQ-002).
REQ-028 max_ed SHALL update when ed_abs > max_ed.
REQ-029 Gaps in s_valid SHALL be tolerated without losing or duplicating samples.
REQ-030 Outputs SHALL hold their final values in DONE until the next accepted start.

Reset
REQ-031 On rst, the FSM SHALL go to IDLE and all pipeline valids SHALL clear.
REQ-032 On rst, these outputs SHALL reset: s_ready=0, busy=0, done=0, sample_count=0, err_count=0, sum_ed_abs=0, max_ed=0.
REQ-033 rst mid-run SHALL abort the run and discard in-flight samples.
REQ-034 A start in the same cycle as rst SHALL be ignored.

Configuration
REQ-035 Macro ERR_STAT_SIGNED_SUM_EN defined: add output sum_ed, signed, SUM_W+1 bits, accumulating exact - apprx per sample, cleared like the other statistics.
REQ-036 Macro ERR_STAT_SIGNED_SUM_EN undefined: sum_ed port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-037 Package err_stat_pkg SHALL hold:
- the FSM state enum;
- the constants OPND_W=8 and PROD_W=16;
- the pipeline stage record typedef.
REQ-038 Stages 1-2 SHALL be one sub-module, err_stat_dp: pure pipeline with valid propagation, no FSM.
REQ-039 The FSM and accumulators SHALL be in the top module.

Verification
REQ-040 Exact samples: start, num_samples=1, sample (3,5,15) -> done, err_count=0, sum_ed_abs=0, max_ed=0, sample_count=1.
REQ-041 Worst case: sample (255,255,0) -> err_count=1, sum_ed_abs=65025, max_ed=65025.
REQ-042 Mixed run, with ERR_STAT_SIGNED_SUM_EN defined:
- Stimulus: num_samples=3, samples (10,10,96), (4,4,20), (0,7,0).
- Required: err_count=2, sum_ed_abs=8, max_ed=4, sum_ed=0.
REQ-043 Backpressure: num_samples=2 with s_valid toggling, then s_valid held high -> exactly 2 transfers; s_ready low from DRAIN onward; done 4 cycles after the 2nd transfer.
REQ-044 Zero and restart:
- start with num_samples=0 -> done next cycle, statistics zero.
- start in DONE -> statistics cleared, new run.
REQ-045 Reset mid-run: rst after 2 of 5 samples -> IDLE, all outputs zero, no late accumulator update.
